// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner encoding, default widths.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (fetch/data) and memory handshake bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    // Handshake: a requester raises *_req with a stable payload and holds it until the edge that
    // samples its one-cycle *_ack. The arbiter holds m_req with stable m_* until a one-cycle m_ack
    // (m_rdata valid with it) or until its watchdog forces completion; m_ack is ignored when m_req=0.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_req, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Access watchdog: counts enabled cycles from a clear and flags the last allowed cycle.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter never wraps: the owner leaves BUSY on the cycle this fires.
    assign expire_o = enable_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and data (D) requesters, data first.
// Optional macro ARB_FAIR_EN: after MAX_DSTREAK data grants with fetch waiting, fetch is granted.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_DSTREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               busy,
    output logic               err,
    output state_e             dbg_state_o
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic              grant_i, grant_d, force_i;
    logic              wd_clear, wd_en, expire;

    assign wd_clear = (state_q != BUSY);
    assign wd_en    = (state_q == BUSY);

    mem_arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wd_clear),
        .enable_i (wd_en),
        .expire_o (expire)
    );

    // Data normally wins: MEM holds the older instruction.
    assign grant_d = (state_q == IDLE) && bus.d_req && !force_i;
    assign grant_i = (state_q == IDLE) && bus.i_req && !grant_d;

`ifdef ARB_FAIR_EN
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!bus.i_req || grant_i) begin
                streak_d = '0;
            end else if (grant_d) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign force_i = bus.i_req && (streak_q == SW'(MAX_DSTREAK));
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    state_d = BUSY;
                end else if (grant_i) begin
                    owner_d = OWN_I;
                    addr_d  = bus.i_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.m_ack) begin
                    if (!we_q) begin
                        if (owner_q == OWN_I) i_rdata_d = bus.m_rdata;
                        else                  d_rdata_d = bus.m_rdata;
                    end
                    state_d = RESP;
                end else if (expire) begin
                    err_d = 1'b1;
                    if (!we_q) begin
                        if (owner_q == OWN_I) i_rdata_d = '0;
                        else                  d_rdata_d = '0;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = (state_q == BUSY);
    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_ack   = (state_q == RESP) && (owner_q == OWN_I);
    assign bus.d_ack   = (state_q == RESP) && (owner_q == OWN_D);
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int T    = 8;
  localparam int MAXS = 4;

  logic   clk;
  logic   rst;
  logic   busy;
  logic   err;
  state_e dbg_state;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (T),
    .MAX_DSTREAK (MAXS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] held_i  = '0;
  logic [31:0] held_d  = '0;
  logic        err_m   = 1'b0;
  int          streak_m = 0;
  bit          spur_en  = 1'b0;
  bit          late_ack = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_val(a);
  endfunction

  // Who gets the port next, given which requesters are waiting at an IDLE decision.
  function automatic owner_e model_pick(input bit pi, input bit pd);
`ifdef ARB_FAIR_EN
    if (pi && streak_m == MAXS) begin
      streak_m = 0;
      return OWN_I;
    end
`endif
    if (!pi) streak_m = 0;
    if (pd) begin
      if (pi) streak_m++;
      return OWN_D;
    end
    streak_m = 0;
    return OWN_I;
  endfunction

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return -1;
    if (r == 1) return T - 1;
    return $urandom_range(0, 4);
  endfunction

  // ---------------- memory responder ----------------
  initial begin : memory_responder
    int cnt;
    int lat;
    bit in_acc;
    cnt = 0;
    lat = -1;
    in_acc = 1'b0;
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      bus.m_ack = 1'b0;
      bus.m_rdata = $urandom;
      if (!rst) begin
        in_acc = 1'b0;
      end else if (late_ack) begin
        bus.m_ack = 1'b1;
        late_ack = 1'b0;
      end else if (bus.m_req) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          cnt = 0;
          lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
        end
        if (lat >= 0 && cnt == lat) begin
          bus.m_ack = 1'b1;
          if (bus.m_we) mem_arr[bus.m_addr] = bus.m_wdata;
          else          bus.m_rdata = mem_read(bus.m_addr);
        end
        cnt++;
      end else begin
        in_acc = 1'b0;
        if (spur_en && $urandom_range(0, 3) == 0) bus.m_ack = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic new_i();
    bus.i_addr = 32'($urandom_range(0, 31) * 4);
  endtask

  task automatic new_d();
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = 32'($urandom_range(0, 15) * 4) + 32'h100;
    bus.d_wdata = $urandom;
  endtask

  // One access granted at the next edge; returns at the negedge where its ack is visible.
  task automatic run_access(input owner_e own, input int lat);
    logic [31:0] ea, ewd, erd;
    logic        ewe, err_prev;
    int          exp_n;
    if (own == OWN_D) begin
      ea = bus.d_addr; ewe = bus.d_we; ewd = bus.d_wdata;
    end else begin
      ea = bus.i_addr; ewe = 1'b0; ewd = '0;
    end
    lat_q.push_back(lat);
    if (!ewe) begin
      erd = (lat < 0) ? 32'h0 : ref_read(ea);
      exp_q.push_back(erd);
    end else if (lat >= 0) begin
      ref_mem[ea] = ewd;
    end
    err_prev = err_m;
    if (lat < 0) err_m = 1'b1;
    exp_n = (lat < 0) ? T + 1 : lat + 2;
    for (int n = 1; n <= exp_n; n++) begin
      @(negedge clk);
      if (n < exp_n) begin
        chk("busy_wait", busy, 1'b1);
        chk("m_req_wait", bus.m_req, 1'b1);
        chk("m_addr", bus.m_addr, ea);
        chk("m_we", bus.m_we, ewe);
        if (ewe) chk("m_wdata", bus.m_wdata, ewd);
        chk("i_ack_wait", bus.i_ack, 1'b0);
        chk("d_ack_wait", bus.d_ack, 1'b0);
        chk("err_wait", err, err_prev);
      end else begin
        chk("m_req_resp", bus.m_req, 1'b0);
        chk("i_ack_resp", bus.i_ack, own == OWN_I);
        chk("d_ack_resp", bus.d_ack, own == OWN_D);
        chk("err_resp", err, err_m);
        if (!ewe) begin
          if (own == OWN_I) held_i = exp_q.pop_front();
          else              held_d = exp_q.pop_front();
        end
        chk("i_rdata", bus.i_rdata, held_i);
        chk("d_rdata", bus.d_rdata, held_d);
      end
    end
  endtask

  // Requesters keep asking until they have n_i / n_d accesses; lat_fix=-2 picks random latency.
  task automatic run_seq(input int n_i, input int n_d, input int lat_fix);
    int     rem_i, rem_d, lat;
    owner_e own;
    rem_i = n_i;
    rem_d = n_d;
    bus.i_req = (rem_i > 0);
    bus.d_req = (rem_d > 0);
    while (rem_i > 0 || rem_d > 0) begin
      own = model_pick(rem_i > 0, rem_d > 0);
      lat = (lat_fix > -2) ? lat_fix : rand_lat();
      run_access(own, lat);
      if (own == OWN_D) begin
        rem_d--;
        if (rem_d > 0) new_d(); else bus.d_req = 1'b0;
      end else begin
        rem_i--;
        if (rem_i > 0) new_i(); else bus.i_req = 1'b0;
      end
      @(negedge clk);
      chk("busy_idle", busy, 1'b0);
      chk("acks_idle", {bus.i_ack, bus.d_ack}, 2'b00);
    end
    @(negedge clk);
    void'(model_pick(1'b0, 1'b0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_m_req", bus.m_req, 1'b0);
    chk("rst_acks", {bus.i_ack, bus.d_ack}, 2'b00);
    chk("rst_i_rdata", bus.i_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    rst = 1'b1;
    spur_en = 1'b1;
    @(negedge clk);

    // Fetch only, m_ack in the second BUSY cycle.
    mem_arr[32'h40] = 32'h2008_0005; ref_mem[32'h40] = 32'h2008_0005;
    bus.i_addr = 32'h40;
    run_seq(1, 0, 1);

    // Simultaneous store and fetch: data first, then fetch; read the store back.
    bus.i_addr = 32'h44;
    bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hCAFE_F00D;
    run_seq(1, 1, 2);
    bus.d_we = 1'b0; bus.d_addr = 32'h100;
    run_seq(0, 1, 0);

    // Immediate m_ack load, then held d_req with fresh addresses back to back.
    mem_arr[32'h200] = 32'h1234_5678; ref_mem[32'h200] = 32'h1234_5678;
    bus.d_we = 1'b0; bus.d_addr = 32'h200;
    run_seq(0, 3, 0);

    // m_ack on the last cycle before the watchdog limit still completes normally.
    bus.i_addr = 32'h4C;
    run_seq(1, 0, T - 1);

    // Watchdog timeout on a fetch; err stays set through later good accesses.
    bus.i_addr = 32'h48;
    run_seq(1, 0, -1);
    new_i(); new_d();
    run_seq(1, 2, 1);

    // Both requesters held high.
    new_i(); new_d();
    run_seq(3, 6, -2);

    for (int k = 0; k < 30; k++) begin
      int ni, nd;
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 3);
      new_i(); new_d();
      if (ni + nd > 0) run_seq(ni, nd, -2);
    end

    // Asynchronous reset in the middle of a BUSY access, then a stray m_ack.
    bus.i_addr = 32'h80; bus.i_req = 1'b1;
    lat_q.push_back(-1);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_m_req", bus.m_req, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_acks", {bus.i_ack, bus.d_ack}, 2'b00);
    chk("arst_i_rdata", bus.i_rdata, 32'h0);
    chk("arst_d_rdata", bus.d_rdata, 32'h0);
    bus.i_req = 1'b0;
    lat_q.delete();
    exp_q.delete();
    err_m = 1'b0; held_i = '0; held_d = '0; streak_m = 0;
    @(negedge clk);
    rst = 1'b1;
    #2 late_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("late_ack_busy", busy, 1'b0);
    chk("late_ack_acks", {bus.i_ack, bus.d_ack}, 2'b00);
    chk("late_ack_m_req", bus.m_req, 1'b0);
    new_i(); new_d();
    run_seq(1, 1, -2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
